// File: rtl/trng_pkg.sv
// Shared types, defaults and parameter sanity checks for the trng_stream slice.
// TRNG_HEALTH_EN adds the FAIL state used by the repetition health monitor.
package trng_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_WARMUP    = 16;
    localparam int DEF_REP_LIMIT = 8;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
`ifdef TRNG_HEALTH_EN
        ,
        ST_FAIL     = 2'd3
`endif
    } trng_state_e;

    function automatic bit params_ok(input int width, input int warmup, input int rep_limit);
        return (width >= 4) && (width % 2 == 0) && (warmup >= 1) && (rep_limit >= 1);
    endfunction

endpackage

// File: rtl/trng_stream_if.sv
// Seed input and valid/ready output stream of trng_stream.
// master = generator side, slave = seed source / consumer side.
interface trng_stream_if #(
    parameter int WIDTH = 16
);
    logic             put_seed;
    logic [WIDTH-1:0] seed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             health_fail;

    modport master (
        input  put_seed, seed, out_ready,
        output out_valid, out_data, busy, health_fail
    );

    modport slave (
        output put_seed, seed, out_ready,
        input  out_valid, out_data, busy, health_fail
    );
endinterface

// File: rtl/trng_step.sv
// Combinational chaotic XOR/ISU step F(S) for any even WIDTH.
module trng_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] f
);
    logic [WIDTH-1:0] b;
    logic             p;
    logic             x;
    logic             y;

    always_comb begin
        p = ^s;
        b = '0;
        f = '0;
        x = 1'b0;
        y = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            b[i] = p ^ s[i] ^ s[(i + 1) % WIDTH];
        end
        // Odd bit of each pair selects the swap, even bit selects output order.
        for (int unsigned k = 0; k < WIDTH / 2; k++) begin
            x = s[2*k+1] ? b[2*k]   : b[2*k+1];
            y = s[2*k+1] ? b[2*k+1] : b[2*k];
            f[2*k]   = s[2*k] ? ~x : ~y;
            f[2*k+1] = s[2*k] ? ~y : ~x;
        end
    end
endmodule

// File: rtl/trng_stream.sv
// Seeded chaotic random word generator with warm-up sequencer and valid/ready output.
// Define TRNG_HEALTH_EN to add the sticky repetition health monitor.
module trng_stream
    import trng_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WARMUP    = DEF_WARMUP,
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input logic          clk,
    input logic          rst,
    trng_stream_if.master bus
);
    localparam int WW = $clog2(WARMUP + 1);

    if (!params_ok(WIDTH, WARMUP, REP_LIMIT)) begin : g_param_check
        $error("trng_stream: WIDTH must be even and >= 4, WARMUP and REP_LIMIT >= 1");
    end

    trng_state_e      state_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_next;
    logic [WW-1:0]    warm_q;

    trng_step #(.WIDTH(WIDTH)) u_step (
        .s (s_q),
        .f (s_next)
    );

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [RW-1:0] rep_q;
    logic [RW-1:0] rep_next;

    // Counts consecutive accepted words that are fixed points of F.
    always_comb begin
        rep_next = '0;
        if (s_next == s_q) begin
            rep_next = (rep_q == RW'(REP_LIMIT)) ? rep_q : rep_q + RW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNSEEDED;
            s_q     <= '0;
            warm_q  <= '0;
`ifdef TRNG_HEALTH_EN
            rep_q   <= '0;
`endif
        end else if (bus.put_seed) begin
            state_q <= ST_WARMUP;
            s_q     <= bus.seed;
            warm_q  <= WW'(WARMUP);
`ifdef TRNG_HEALTH_EN
            rep_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    s_q    <= s_next;
                    warm_q <= warm_q - WW'(1);
                    if (warm_q == WW'(1)) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.out_ready) begin
                        s_q <= s_next;
`ifdef TRNG_HEALTH_EN
                        rep_q <= rep_next;
                        if (rep_next == RW'(REP_LIMIT)) begin
                            state_q <= ST_FAIL;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (state_q == ST_RUN);
    assign bus.out_data  = (state_q == ST_RUN) ? s_q : '0;
    assign bus.busy      = (state_q == ST_WARMUP);
`ifdef TRNG_HEALTH_EN
    assign bus.health_fail = (state_q == ST_FAIL);
`else
    assign bus.health_fail = 1'b0;
`endif
endmodule

// File: tb/tb_trng_stream.sv
// Scoreboard bench for trng_stream: stimulus queues predicted words, monitors pop on handshakes.
// Health scenario follows TRNG_HEALTH_EN when the bench is built with the same macro.
module tb_trng_stream;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    trng_stream_if #(.WIDTH(16)) b16 ();
    trng_stream_if #(.WIDTH(4))  b4 ();
    trng_stream_if #(.WIDTH(16)) bh ();

    trng_stream #(.WIDTH(16), .WARMUP(16), .REP_LIMIT(8)) u16 (.clk(clk), .rst(rst), .bus(b16));
    trng_stream #(.WIDTH(4),  .WARMUP(1),  .REP_LIMIT(8)) u4  (.clk(clk), .rst(rst), .bus(b4));
    trng_stream #(.WIDTH(16), .WARMUP(1),  .REP_LIMIT(3)) uh  (.clk(clk), .rst(rst), .bus(bh));

    logic [15:0] q16[$];
    logic [15:0] q4[$];
    logic [15:0] qh[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference step taken straight from the pairwise rules, for any even width up to 16.
    function automatic logic [15:0] mstep(input logic [15:0] s, input int w);
        logic [15:0] r = '0;
        logic [15:0] b = '0;
        logic        p = 1'b0;
        logic        x, y;
        for (int i = 0; i < w; i++) p ^= s[i];
        for (int i = 0; i < w; i++) b[i] = p ^ s[i] ^ s[(i + 1) % w];
        for (int k = 0; k < w / 2; k++) begin
            {x, y} = s[2*k+1] ? {b[2*k], b[2*k+1]} : {b[2*k+1], b[2*k]};
            r[2*k]   = s[2*k] ? ~x : ~y;
            r[2*k+1] = s[2*k] ? ~y : ~x;
        end
        return r;
    endfunction

    // Monitor for the 16/16 instance: word order, stall stability, zero when idle.
    logic        pv = 1'b0, pr = 1'b0, ps = 1'b1;
    logic [15:0] pd = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr && !ps) begin
                check("stall_valid", b16.out_valid, 1);
                check("stall_data", b16.out_data, pd);
            end
            if (!b16.out_valid) check("idle_data_zero", b16.out_data, 0);
            if (b16.out_valid && b16.out_ready) begin
                if (q16.size() == 0) check("word16_unexpected", 1, 0);
                else check("word16", b16.out_data, q16.pop_front());
            end
        end
        pv <= b16.out_valid;
        pr <= b16.out_ready;
        ps <= b16.put_seed | rst;
        pd <= b16.out_data;
    end

    always @(negedge clk) begin
        if (!rst && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) check("word4_unexpected", 1, 0);
            else check("word4", b4.out_data, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && bh.out_valid && bh.out_ready) begin
            if (qh.size() == 0) check("wordh_unexpected", 1, 0);
            else check("wordh", bh.out_data, qh.pop_front());
        end
    end

    // Seeds the 16/16 instance, queues its predicted stream and checks warm-up timing.
    // stop_at > 0 returns after that many warm-up edges (for a mid-warm-up reseed).
    task automatic seed16(input logic [15:0] v, input int stop_at);
        logic [15:0] m;
        logic [15:0] first;
        b16.seed     = v;
        b16.put_seed = 1'b1;
        @(posedge clk);
        #1 b16.put_seed = 1'b0;
        q16.delete();
        m = v;
        repeat (16) m = mstep(m, 16);
        first = m;
        for (int n = 0; n < 256; n++) begin
            q16.push_back(m);
            m = mstep(m, 16);
        end
        check("seed_busy", b16.busy, 1);
        check("seed_valid", b16.out_valid, 0);
        for (int j = 1; j < 16; j++) begin
            @(posedge clk);
            #1;
            if (j == stop_at) return;
            check("warm_busy", b16.busy, 1);
            check("warm_valid", b16.out_valid, 0);
        end
        @(posedge clk);
        #1;
        check("warm_done_busy", b16.busy, 0);
        check("warm_done_valid", b16.out_valid, 1);
        check("warm_done_data", b16.out_data, first);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b16.put_seed = 1'b0; b16.seed = '0; b16.out_ready = 1'b0;
        b4.put_seed  = 1'b0; b4.seed  = '0; b4.out_ready  = 1'b0;
        bh.put_seed  = 1'b0; bh.seed  = '0; bh.out_ready  = 1'b0;

        // Reset for two cycles, then idle for ten.
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) rst = 1'b0;
            check("idle16", {b16.out_valid, b16.busy, b16.health_fail, b16.out_data}, 0);
            check("idle4",  {b4.out_valid,  b4.busy,  b4.health_fail,  b4.out_data},  0);
            check("idleh",  {bh.out_valid,  bh.busy,  bh.health_fail,  bh.out_data},  0);
        end

        // Warm-up latency from seed 0xACE1 with the consumer stalled.
        seed16(16'hACE1, 0);

        // Random backpressure.
        for (int c = 0; c < 200; c++) begin
            b16.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end

        // Reseed on the same edge as a handshake, then again mid-warm-up.
        b16.out_ready = 1'b1;
        @(posedge clk);
        #1 check("pre_collision_valid", b16.out_valid, 1);
        seed16(16'($urandom), 5);
        seed16(16'($urandom), 0);
        repeat (8) begin
            b16.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        b16.out_ready = 1'b0;

        // Known 4-bit sequence.
        q4.push_back(4'hA); q4.push_back(4'h0);
        q4.push_back(4'hF); q4.push_back(4'hF); q4.push_back(4'hF);
        b4.out_ready = 1'b1;
        b4.seed      = 4'h1;
        b4.put_seed  = 1'b1;
        @(posedge clk);
        #1 b4.put_seed = 1'b0;
        for (int c = 0; c < 20 && q4.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        b4.out_ready = 1'b0;
        check("seq4_drained", q4.size(), 0);
        @(posedge clk);
        #1 check("seq4_stuck", {b4.out_valid, b4.out_data}, {1'b1, 4'hF});

        // All-zero seed falls into the all-ones fixed point.
        bh.out_ready = 1'b1;
        bh.seed      = 16'h0000;
        bh.put_seed  = 1'b1;
        @(posedge clk);
        #1 bh.put_seed = 1'b0;
`ifdef TRNG_HEALTH_EN
        repeat (3) qh.push_back(16'hFFFF);
`else
        repeat (6) qh.push_back(16'hFFFF);
`endif
        for (int c = 0; c < 20 && qh.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("health_drained", qh.size(), 0);
`ifdef TRNG_HEALTH_EN
        check("health_valid_low", bh.out_valid, 0);
        check("health_fail_set", bh.health_fail, 1);
        check("health_busy_low", bh.busy, 0);
        repeat (3) @(posedge clk);
        #1 check("health_sticky", {bh.out_valid, bh.health_fail}, 2'b01);
        bh.out_ready = 1'b0;
        bh.seed      = 16'h1234;
        bh.put_seed  = 1'b1;
        @(posedge clk);
        #1 bh.put_seed = 1'b0;
        check("health_cleared", bh.health_fail, 0);
        check("health_rewarm", bh.busy, 1);
        @(posedge clk);
        #1 check("health_resume", {bh.out_valid, bh.out_data}, {1'b1, mstep(16'h1234, 16)});
`else
        bh.out_ready = 1'b0;
        @(posedge clk);
        #1 check("stuck_streams", {bh.out_valid, bh.health_fail, bh.out_data}, {2'b10, 16'hFFFF});
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_stream.md
# trng_stream

Parametrised successor to the 16-bit chaotic XOR/ISU random generator. It is generalised to any even `WIDTH` and wraps the chaotic state register in a seeded warm-up sequencer and a valid/ready output stream. An optional repetition health monitor is included. It sits between seed logic (firmware or the entropy collector) and downstream consumers of random words.

## Interface
Parameters:
- `WIDTH`, default 16: state and word width. Must be even and ≥ 4.
- `WARMUP`, default 16: number of state steps discarded after each seed load. Must be ≥ 1.
- `REP_LIMIT`, default 8: consecutive self-repeating accepted words that trip the health test. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `put_seed`, input, 1: load `seed` this cycle. Accepted in any state.
- `seed`, input, `WIDTH`: seed value.
- `out_valid`, output, 1: `out_data` holds a fresh word.
- `out_ready`, input, 1: consumer accepts the word.
- `out_data`, output, `WIDTH`: random word. Zero whenever `out_valid`=0.
- `busy`, output, 1: high during warm-up.
- `health_fail`, output, 1: sticky health alarm. Tied to 0 without the macro.

## Operation
Step function F(S), with p = XOR-reduce of S and indices mod `WIDTH`:
- B[i] = p ^ S[i] ^ S[(i+1) mod WIDTH].
- For each pair k: x = S[2k+1] ? B[2k] : B[2k+1], and y = S[2k+1] ? B[2k+1] : B[2k].
- Fn[2k] = S[2k] ? ~x : ~y, and Fn[2k+1] = S[2k] ? ~y : ~x.
- Consequence: all-ones is a fixed point, and all-zero maps to all-ones.

States: UNSEEDED, WARMUP, RUN, plus FAIL when the macro is defined.
- UNSEEDED: S=0, `out_valid`=0. Exited only by `put_seed`.
- `put_seed` (from any state): S←seed, warm counter←WARMUP, rep counter←0, `health_fail`←0, go to WARMUP.
- WARMUP: S←F(S) every cycle and the counter decrements. After the WARMUP-th step, go to RUN.
- RUN: `out_valid`=1 and `out_data`=S. On `out_valid`&`out_ready`, S←F(S). With no handshake, S holds.
- `put_seed` has priority over every other event. If it coincides with a RUN handshake, the presented word counts as delivered and the reload wins.

## Timing
Reset values:
- S=0, state UNSEEDED.
- `out_valid`=0, `out_data`=0, `busy`=0, `health_fail`=0.
- `rst` has priority over `put_seed`.

Latency and handshake:
- `put_seed` sampled at edge k: `busy`=1 after edge k.
- `out_valid`=1 after edge k+WARMUP, with S = F^WARMUP(seed).
- Throughput is one word per cycle while `out_ready`=1.
- `out_data` stays stable while `out_valid`&!`out_ready`.
- `out_valid` does not drop in RUN except on `put_seed`, `rst`, or FAIL.
- `put_seed` during WARMUP restarts the full WARMUP count.

Counters:
- Warm counter width is $clog2(WARMUP+1).
- Rep counter saturates at REP_LIMIT.

## Configuration
- `TRNG_HEALTH_EN` defined:
  - On each RUN handshake, if F(S)==S the rep counter increments; otherwise it clears.
  - When the counter reaches REP_LIMIT, the next state is FAIL: `out_valid`=0, `health_fail`=1, `busy`=0.
  - FAIL is left only via `put_seed` or `rst`.
- `TRNG_HEALTH_EN` undefined:
  - No rep counter and no FAIL state. `health_fail` is constant 0.
  - A stuck state streams indefinitely.

## Structure
- Package `trng_pkg` holds:
  - the state enum `trng_state_e`;
  - localparam checks (even WIDTH ≥ 4, WARMUP ≥ 1);
  - the default constants.
- Sub-module `trng_step #(WIDTH)` is purely combinational and implements F. The reference-model check in the bench uses the same equations.
- Top level `trng_stream` contains the FSM, the state register, the counters and the optional health logic.

## Test plan
- Reset: `rst`=1 for 2 cycles, then idle 10 cycles. Required: `out_valid`=0, `out_data`=0, `busy`=0, `health_fail`=0 throughout.
- Warm-up latency (WIDTH=16, WARMUP=16): `put_seed` with seed 0xACE1 at edge k. Required: `busy`=1 for edges k+1..k+16, `out_valid` rises after edge k+16, and `out_data` = model F^16(0xACE1).
- Known sequence (WIDTH=4, WARMUP=1, macro off, seed 0x1, `out_ready`=1). Required: words 0xA, 0x0, 0xF, 0xF, 0xF.
- Backpressure (WIDTH=16): toggle `out_ready` randomly for 200 cycles. Required: `out_data` holds while stalled, and the accepted words match successive model F steps with no skips or duplicates.
- Health (WIDTH=16, WARMUP=1, REP_LIMIT=3, macro on, seed 0x0000, `out_ready`=1). Required:
  - exactly 3 words of 0xFFFF are accepted;
  - then `out_valid`=0 and `health_fail`=1;
  - `put_seed` with 0x1234 clears `health_fail` and re-enters WARMUP.
- Collision: `put_seed` asserted on the same edge as a RUN handshake, and again mid-WARMUP. Required: the reload wins in both cases, the warm-up restarts the full count, and no extra word is produced.
